// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter that hands each granted requester one LFSR sample scaled into [BASE, BASE+RANGE).
// Define RAND_NO_REPEAT_EN to resample (up to MAX_RETRY times) when a value would repeat the last one delivered.
module lfsr_rand_arbiter #(
  parameter int N_REQ     = 4,
  parameter int RANGE     = 640,
  parameter int BASE      = 0,
  parameter int MAX_RETRY = 3,
  localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      lfsr_q,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [15:0]      rand_out,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  output logic             lfsr_fault
);

  typedef enum logic [1:0] {IDLE, SAMPLE, SCALE, DONE} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] ptr;
  logic [GW-1:0] sel;
  logic          found;
  logic [15:0]   sample;
  logic [15:0]   scaled;
  logic          retry_hit;

  function automatic logic [15:0] scale_coord(input logic [15:0] s);
    return 16'((32'(s) * 32'(RANGE)) >> 16) + 16'(BASE);
  endfunction

  assign scaled = scale_coord(sample);

  // First requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

`ifdef RAND_NO_REPEAT_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry;

  // rand_out doubles as the last-delivered value; both reset to 0.
  assign retry_hit = (scaled == rand_out) && (retry < RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry <= '0;
    end else if (state == IDLE) begin
      retry <= '0;
    end else if (state == SCALE && retry_hit) begin
      retry <= retry + RW'(1);
    end
  end
`else
  assign retry_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = SCALE;
      SCALE:   state_nxt = retry_hit ? SAMPLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      ptr        <= '0;
      rand_out   <= '0;
      lfsr_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) grant_id <= sel;
      if (state == SAMPLE && lfsr_q == 16'h0000) lfsr_fault <= 1'b1;
      // Loaded on the way into DONE so the value is present alongside ack.
      if (state == SCALE && !retry_hit) rand_out <= scaled;
      if (state == DONE) ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == SAMPLE) sample <= lfsr_q;
  end

  assign ack  = (state == DONE) ? (N_REQ'(1) << grant_id) : '0;
  assign busy = (state != IDLE);

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
Shares the free-running 16-bit LFSR output between N_REQ game-logic requesters, such as alien spawners and bomb droppers. Each granted request receives one random coordinate scaled into [BASE, BASE+RANGE). Requesters are served one at a time under round-robin priority, with a level req / pulse ack handshake. The block sits between the LFSR and the alien placement logic.

Parameters:
N_REQ, 4, number of requesters (2..8)
RANGE, 640, size of the output coordinate range (1..65535)
BASE, 0, offset added to the scaled value
MAX_RETRY, 3, maximum resamples per grant when the no-repeat feature is compiled in

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
lfsr_q  in  16  current LFSR value; advances every clk
req  in  N_REQ  per-requester request level
ack  out  N_REQ  one-hot, one-cycle grant-complete pulse
rand_out  out  16  scaled random value; valid while ack is nonzero, held afterwards
grant_id  out  max(1,$clog2(N_REQ))  index of the requester currently being served
busy  out  1  high in any state except IDLE
lfsr_fault  out  1  sticky; set when a sampled lfsr_q equals 0x0000 (LFSR lock-up)

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; ack=0; rand_out=0; grant_id=0; busy=0; lfsr_fault=0.
  - Priority pointer=0, retry count=0, last value=0.
  - Takes effect mid-transaction: an in-flight grant is dropped and no ack is issued.
- FSM states: IDLE, SAMPLE, SCALE, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - If req != 0, select the first set bit at or above the priority pointer, wrapping modulo N_REQ.
  - Latch that index into grant_id, clear retry count, go to SAMPLE.
  - Otherwise stay in IDLE.
- SAMPLE:
  - Capture lfsr_q into the sample register.
  - If lfsr_q==0, set lfsr_fault (sticky until reset); the sample is still used.
  - Go to SCALE.
- SCALE:
  - Compute scaled = ((sample * RANGE) >> 16) + BASE, using a 32-bit product truncated to 16 bits after the add. Result is always in [BASE, BASE+RANGE-1].
  - Go to DONE, except for the retry case under the optional feature.
- DONE:
  - rand_out=scaled; ack[grant_id]=1 for exactly this cycle; last value=scaled.
  - Priority pointer=(grant_id+1) mod N_REQ. Go to IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle n → ack at cycle n+3 (without retries).
  - Maximum rate is one grant per 4 cycles.
- Handshake:
  - A requester holds req until it sees its ack bit, then deasserts it on the next cycle.
  - A req still high when the FSM re-enters IDLE is arbitrated again as a new request.
  - A req dropped after grant does not cancel the transaction; ack is still issued.
  - req changes during SAMPLE, SCALE or DONE are ignored.
- Simultaneous requests: exactly one grant per IDLE pass. Round-robin guarantees each active requester is served within N_REQ grants.
- Wrap-around: the pointer goes from N_REQ-1 to 0. With grant at N_REQ-1, search order is 0,1,...

Optional Feature:
RAND_NO_REPEAT_EN:
- Defined:
  - In SCALE, if scaled equals the last delivered value and retry < MAX_RETRY, increment retry and return to SAMPLE, adding 2 cycles per retry.
  - When retry reaches MAX_RETRY, the repeated value is delivered anyway.
  - Worst-case latency is 3+2*MAX_RETRY cycles.
  - The last value register resets to 0.
- Undefined: there is no compare, no retry counter and no extra latency; SCALE always goes to DONE.

Test Plan:
Scaling, RANGE=640, BASE=0: req=4'b0001, lfsr_q held at 0x8000 → ack=4'b0001 three cycles after request seen in IDLE, rand_out=320; with lfsr_q=0xFFFF → rand_out=639; with lfsr_q=0x0001 → rand_out=0.
Round-robin: req=4'b1111 held and re-raised after each ack → grant_id sequence 0,1,2,3,0; one ack every 4 cycles; no ack bit set two cycles in a row.
Priority pointer and wrap: after a grant to 2, req=4'b0011 → next grant 0; then req=4'b0110 → next grant 1.
Fault: lfsr_q=0x0000 during SAMPLE → lfsr_fault=1 and stays 1 through later grants with nonzero lfsr_q; rand_out=BASE=0; only reset clears it.
Reset mid-operation: assert reset low while in SCALE → outputs go to 0 immediately without a clock edge; no ack after release; next request is served starting from requester 0.
No-repeat (RAND_NO_REPEAT_EN, MAX_RETRY=3): two requests with lfsr_q fixed at 0x8000 → first ack at +3 cycles with 320. Second ack at +9 cycles, still with 320 after 3 retries. If lfsr_q changes to 0x4000 during a retry → 160 is delivered at that point.
